// File: rtl/instr_dispatcher.sv
// -----------------------------------------------------------------------------
// instr_dispatcher
//
// Instruction front-end for the systolic array. Buffers incoming instructions
// in a DEPTH-entry circular queue and issues them one at a time to the
// execution engine once every operand source reports ready. It then waits for
// the engine's completion pulse before issuing the next one.
//
// Parameters:
//   INSTR_W  instruction word width
//   DEPTH    queue entries (power of two, >= 2)
//   NUM_SRC  number of operand-source ready inputs
//   CNT_W    completed-instruction counter width (wraps)
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   instr_valid   producer offers instr
//   instr         instruction word
//   src_ready     per-source operand ready (bit 0 = A, bit 1 = B, ...)
//   ack           one-cycle pulse: instruction accepted
//   issue_valid   one-cycle pulse: issue_instr presented to the engine
//   issue_instr   instruction being issued, held until the next issue
//   exec_done     one-cycle pulse from the engine: issued instruction finished
//   done          queue empty, engine idle, >=1 completion since last accept
//   fifo_level    current queue occupancy
//   completed     completed-instruction count (modulo 2^CNT_W)
//   err           sticky: exec_done seen while nothing was outstanding
//   busy_cycles   cycles spent in ISSUE or WAIT_DONE (saturating)
//   stall_cycles  cycles idle with work queued but operands not ready
//
// Configuration macro:
//   INSTR_PERF_CNT_EN  when defined, busy_cycles/stall_cycles are live
//                      saturating counters; otherwise both are tied to 0.
// -----------------------------------------------------------------------------
module instr_dispatcher #(
  parameter int INSTR_W = 71,
  parameter int DEPTH   = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       instr_valid,
  input  logic [INSTR_W-1:0]         instr,
  input  logic [NUM_SRC-1:0]         src_ready,
  output logic                       ack,
  output logic                       issue_valid,
  output logic [INSTR_W-1:0]         issue_instr,
  input  logic                       exec_done,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [CNT_W-1:0]           completed,
  output logic                       err,
  output logic [31:0]                busy_cycles,
  output logic [31:0]                stall_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [INSTR_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic [LVL_W-1:0]     w_level_next;

  logic                 r_ack;
  logic                 r_issue_valid;
  logic [INSTR_W-1:0]   r_issue_instr;
  logic                 r_done;
  logic                 r_cmpl_seen;   // a completion happened since the last accept
  logic [CNT_W-1:0]     r_completed;
  logic                 r_err;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_src_all_ready;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_complete;
  logic                 w_spurious;
  logic                 w_cmpl_seen_next;
  logic                 w_done_next;

  assign w_full          = (r_level == LVL_W'(DEPTH));
  assign w_empty         = (r_level == '0);
  assign w_src_all_ready = &src_ready;

  // Fullness is judged on the current level, so a pop in the same cycle does
  // not open a slot until the following edge. The ack cycle never accepts,
  // which lets the producer drop valid without a duplicate push.
  assign w_push = instr_valid && !r_ack && !w_full;

  // ---------------------------------------------------------------------------
  // FSM next-state and control
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_complete   = 1'b0;
    w_spurious   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty && w_src_all_ready) w_state_next = S_ISSUE;
        if (exec_done)                   w_spurious   = 1'b1;
      end
      S_ISSUE: begin
        w_pop        = 1'b1;
        w_state_next = S_WAIT_DONE;
        if (exec_done) w_spurious = 1'b1;
      end
      S_WAIT_DONE: begin
        if (exec_done) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_level_next = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LVL_W'(1);
      2'b01:   w_level_next = r_level - LVL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  assign w_cmpl_seen_next = w_push ? 1'b0 : (w_complete ? 1'b1 : r_cmpl_seen);
  assign w_done_next      = (w_state_next == S_IDLE) && (w_level_next == '0) &&
                            w_cmpl_seen_next;

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; emptiness is tracked by the pointers
  // and level alone, so stale words are unreachable after reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= instr;
  end

  // ---------------------------------------------------------------------------
  // State, pointers and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_ack         <= 1'b0;
      r_issue_valid <= 1'b0;
      r_issue_instr <= '0;
      r_done        <= 1'b0;
      r_cmpl_seen   <= 1'b0;
      r_completed   <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_level       <= w_level_next;
      r_ack         <= w_push;
      r_cmpl_seen   <= w_cmpl_seen_next;
      r_done        <= w_done_next;
      r_issue_valid <= (r_state == S_IDLE) && (w_state_next == S_ISSUE);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // Head is captured on entry to ISSUE; it is popped on leaving ISSUE.
      if ((r_state == S_IDLE) && (w_state_next == S_ISSUE))
        r_issue_instr <= r_mem[r_rd_ptr];
      if (w_complete) r_completed <= r_completed + CNT_W'(1);
      if (w_spurious) r_err       <= 1'b1;
    end
  end

  assign ack         = r_ack;
  assign issue_valid = r_issue_valid;
  assign issue_instr = r_issue_instr;
  assign done        = r_done;
  assign fifo_level  = r_level;
  assign completed   = r_completed;
  assign err         = r_err;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef INSTR_PERF_CNT_EN
  logic [31:0] r_busy_cycles;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy_cycles  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_busy_cycles != '1))
        r_busy_cycles <= r_busy_cycles + 32'd1;
      if ((r_state == S_IDLE) && !w_empty && !w_src_all_ready &&
          (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign busy_cycles  = r_busy_cycles;
  assign stall_cycles = r_stall_cycles;
`else
  assign busy_cycles  = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_instr_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_instr_dispatcher
//
// Directed self-checking bench for instr_dispatcher (INSTR_W=71, DEPTH=4,
// NUM_SRC=2, CNT_W=2 so the completion counter wraps within the run).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_instr_dispatcher;

  localparam int INSTR_W = 71;
  localparam int DEPTH   = 4;
  localparam int NUM_SRC = 2;
  localparam int CNT_W   = 2;
  localparam int LVL_W   = $clog2(DEPTH+1);

  logic               clk = 1'b0;
  logic               rst;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [NUM_SRC-1:0] src_ready;
  logic               ack;
  logic               issue_valid;
  logic [INSTR_W-1:0] issue_instr;
  logic               exec_done;
  logic               done;
  logic [LVL_W-1:0]   fifo_level;
  logic [CNT_W-1:0]   completed;
  logic               err;
  logic [31:0]        busy_cycles;
  logic [31:0]        stall_cycles;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_dispatcher #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .NUM_SRC (NUM_SRC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .src_ready    (src_ready),
    .ack          (ack),
    .issue_valid  (issue_valid),
    .issue_instr  (issue_instr),
    .exec_done    (exec_done),
    .done         (done),
    .fifo_level   (fifo_level),
    .completed    (completed),
    .err          (err),
    .busy_cycles  (busy_cycles),
    .stall_cycles (stall_cycles)
  );

  // Hand-picked instruction words, distinct in both upper and lower bits.
  localparam logic [INSTR_W-1:0] I0  = {7'h41, 64'h0123_4567_89AB_CDEF};
  localparam logic [INSTR_W-1:0] I1  = {7'h11, 64'h1111_0000_0000_0001};
  localparam logic [INSTR_W-1:0] I2  = {7'h22, 64'h2222_0000_0000_0002};
  localparam logic [INSTR_W-1:0] I3  = {7'h33, 64'h3333_0000_0000_0003};
  localparam logic [INSTR_W-1:0] I4  = {7'h44, 64'h4444_0000_0000_0004};
  localparam logic [INSTR_W-1:0] I5  = {7'h55, 64'h5555_0000_0000_0005};
  localparam logic [INSTR_W-1:0] I6  = {7'h66, 64'h6666_DEAD_0000_0006};
  localparam logic [INSTR_W-1:0] I7  = {7'h77, 64'h7777_DEAD_0000_0007};
  localparam logic [INSTR_W-1:0] I8  = {7'h08, 64'h8888_DEAD_0000_0008};
  localparam logic [INSTR_W-1:0] I9  = {7'h19, 64'h9999_BEEF_0000_0009};
  localparam logic [INSTR_W-1:0] I10 = {7'h2A, 64'hAAAA_BEEF_0000_000A};

`ifdef INSTR_PERF_CNT_EN
  localparam logic [31:0] EXP_BUSY_ONE = 32'd5;
  localparam logic [31:0] EXP_STALL_10 = 32'd10;
`else
  localparam logic [31:0] EXP_BUSY_ONE = 32'd0;
  localparam logic [31:0] EXP_STALL_10 = 32'd0;
`endif

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and expect it to be accepted on the first edge.
  task automatic push(input logic [INSTR_W-1:0] word, input logic [LVL_W-1:0] exp_lvl);
    instr_valid = 1'b1;
    instr       = word;
    tick();
    check("push_ack", ack, 1'b1);
    check("push_level", fifo_level, exp_lvl);
    instr_valid = 1'b0;
    tick();
    check("push_ack_pulse", ack, 1'b0);
  endtask

  // Wait (bounded) for an issue, check the word, then complete it after
  // exec_done arrives on the 5th edge following the issue.
  task automatic run_issue(input string tag, input logic [INSTR_W-1:0] word,
                           input logic [CNT_W-1:0] exp_cnt);
    int n = 0;
    while (!issue_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_issue_valid"}, issue_valid, 1'b1);
    check({tag, "_issue_instr"}, issue_instr, word);
    repeat (4) tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check({tag, "_completed"}, completed, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    src_ready   = '0;
    exec_done   = 1'b0;

    // ---- Reset values ------------------------------------------------------
    #3;
    check("rst_ack",         ack,          1'b0);
    check("rst_issue_valid", issue_valid,  1'b0);
    check("rst_issue_instr", issue_instr,  '0);
    check("rst_done",        done,         1'b0);
    check("rst_level",       fifo_level,   '0);
    check("rst_completed",   completed,    '0);
    check("rst_err",         err,          1'b0);
    check("rst_busy",        busy_cycles,  '0);
    check("rst_stall",       stall_cycles, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // ---- Single instruction, sources ready ---------------------------------
    src_ready   = 2'b11;
    instr_valid = 1'b1;
    instr       = I0;
    tick();
    check("t1_ack",         ack,         1'b1);
    check("t1_level",       fifo_level,  3'd1);
    check("t1_no_issue",    issue_valid, 1'b0);
    check("t1_done_low",    done,        1'b0);
    instr_valid = 1'b0;
    tick();
    check("t1_ack_pulse",   ack,         1'b0);
    check("t1_issue_valid", issue_valid, 1'b1);
    check("t1_issue_instr", issue_instr, I0);
    tick();
    check("t1_issue_pulse", issue_valid, 1'b0);
    check("t1_level_pop",   fifo_level,  3'd0);
    check("t1_issue_hold",  issue_instr, I0);
    repeat (3) tick();
    check("t1_done_wait",   done,        1'b0);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("t1_completed",   completed,   2'd1);
    check("t1_done",        done,        1'b1);
    check("t1_busy",        busy_cycles, EXP_BUSY_ONE);

    // ---- Fill queue with sources not ready; fifth held off ------------------
    src_ready = 2'b00;
    instr_valid = 1'b1;
    instr       = I1;
    tick();
    check("t2_ack0",      ack,  1'b1);
    check("t2_done_clr",  done, 1'b0);
    instr_valid = 1'b0;
    tick();
    push(I2, 3'd2);
    push(I3, 3'd3);
    push(I4, 3'd4);
    instr_valid = 1'b1;
    instr       = I5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_full_no_ack", ack,        1'b0);
      check("t2_full_level",  fifo_level, 3'd4);
    end
    src_ready = 2'b11;
    tick();
    check("t2_issue0_valid", issue_valid, 1'b1);
    check("t2_issue0_instr", issue_instr, I1);
    check("t2_pop_edge_ack", ack,         1'b0);
    tick();
    check("t2_refused_ack",  ack,         1'b0);
    check("t2_after_pop",    fifo_level,  3'd3);
    tick();
    check("t2_fifth_ack",    ack,         1'b1);
    check("t2_fifth_level",  fifo_level,  3'd4);
    instr_valid = 1'b0;
    repeat (2) tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("t2_cmp_i1", completed, 2'd2);
    run_issue("t2_i2", I2, 2'd3);
    run_issue("t2_i3", I3, 2'd0);
    run_issue("t2_i4", I4, 2'd1);
    run_issue("t2_i5", I5, 2'd2);
    check("t2_drained", fifo_level, 3'd0);
    check("t2_done",    done,       1'b1);

    // ---- Spurious exec_done in IDLE ----------------------------------------
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("t4_err",       err,       1'b1);
    check("t4_completed", completed, 2'd2);
    check("t4_done",      done,      1'b1);
    repeat (3) tick();
    check("t4_err_sticky", err, 1'b1);

    // ---- Reset in WAIT_DONE with two queued --------------------------------
    src_ready = 2'b00;
    push(I6, 3'd1);
    push(I7, 3'd2);
    push(I8, 3'd3);
    src_ready = 2'b11;
    run_issue_partial: begin
      int n = 0;
      while (!issue_valid && n < 20) begin
        tick();
        n++;
      end
    end
    check("t5_issue_instr", issue_instr, I6);
    tick();
    check("t5_wait_level", fifo_level, 3'd2);
    #2 rst = 1'b0;
    #1;
    check("t5_ack",         ack,          1'b0);
    check("t5_issue_valid", issue_valid,  1'b0);
    check("t5_issue_instr", issue_instr,  '0);
    check("t5_done",        done,         1'b0);
    check("t5_level",       fifo_level,   '0);
    check("t5_completed",   completed,    '0);
    check("t5_err",         err,          1'b0);
    check("t5_busy",        busy_cycles,  '0);
    check("t5_stall",       stall_cycles, '0);
    #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_no_stale_issue", issue_valid, 1'b0);
    end
    check("t5_level_after", fifo_level, 3'd0);
    push(I9, 3'd1);
    run_issue("t5_i9", I9, 2'd1);
    check("t5_busy_i9", busy_cycles, EXP_BUSY_ONE);

    // ---- Partial readiness stalls ------------------------------------------
    src_ready = 2'b01;
    push(I10, 3'd1);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("t3_no_issue", issue_valid, 1'b0);
    end
    check("t3_stall", stall_cycles, EXP_STALL_10);
    src_ready = 2'b11;
    run_issue("t3_i10", I10, 2'd2);
    check("t3_done", done, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_dispatcher.md
# instr_dispatcher

Parametrised instruction front-end for the systolic accelerator top level. It replaces the single-shot `instr_valid`/`ack` capture with a DEPTH-entry instruction queue. Each queued instruction is issued to the execution engine only when every operand source reports ready. The block then tracks completion and raises `done` once the queue drains. It sits between the host/bench instruction port and the array controller, and generalises instruction width, queue depth and operand-source count.

## Interface
- `INSTR_W`, 71, instruction word width
- `DEPTH`, 4, queue entries; power of two, ≥2
- `NUM_SRC`, 2, number of operand-buffer ready inputs (A, B, …)
- `CNT_W`, 16, completed-instruction counter width
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-low reset
- `instr_valid` in 1 — producer offers `instr`
- `instr` in INSTR_W — instruction word
- `src_ready` in NUM_SRC — per-source operand ready (bit 0 = A, bit 1 = B)
- `ack` out 1 — one-cycle pulse: instruction accepted
- `issue_valid` out 1 — one-cycle pulse: `issue_instr` valid to engine
- `issue_instr` out INSTR_W — instruction being issued, held until next issue
- `exec_done` in 1 — one-cycle pulse from engine: issued instruction finished
- `done` out 1 — level: queue empty, engine idle, ≥1 completion since last accept
- `fifo_level` out $clog2(DEPTH+1) — current occupancy
- `completed` out CNT_W — completed-instruction count, wraps modulo 2^CNT_W
- `err` out 1 — sticky protocol error
- `busy_cycles` out 32, `stall_cycles` out 32 — performance counters (see Configuration)

## Operation
- Accept: on a clock edge with `instr_valid`=1, `ack`=0 and `fifo_level`<DEPTH, push `instr`; `ack`=1 the next cycle for exactly one cycle. No accept while `ack`=1. The producer drops `instr_valid` during the ack cycle; a still-high valid after that cycle is a new instruction.
- Full: `instr_valid` is held off with no ack and no push. The push is refused even if a pop occurs in the same cycle.
- Queue: circular buffer, read/write pointers wrap at DEPTH, FIFO order preserved.
- FSM IDLE → ISSUE when queue non-empty and `&src_ready`=1.
- FSM ISSUE → WAIT_DONE unconditionally. In ISSUE, `issue_valid`=1, `issue_instr` ← head, pop.
- FSM WAIT_DONE → IDLE on `exec_done`; `completed`+1.
- Push and pop in the same cycle: `fifo_level` unchanged.
- `exec_done` in IDLE or ISSUE: ignored for state and count; sets `err`. `err` is cleared only by reset.
- `done`: set when in IDLE, queue empty and `completed` advanced since the last accept; cleared on the cycle of the next accept.
- Reset (async, any state, mid-operation included) returns the FSM to IDLE and empties the queue. The queue contents are not cleared.

## Timing
- Reset values: `ack`=0, `issue_valid`=0, `issue_instr`=0, `done`=0, `fifo_level`=0, `completed`=0, `err`=0, `busy_cycles`=0, `stall_cycles`=0.
- Accept edge → `ack` high next cycle; `fifo_level` updates the same edge.
- Empty queue with sources ready: `issue_valid` rises 2 cycles after the accept edge (push edge, then IDLE→ISSUE edge).
- `src_ready` is sampled only in IDLE; deassertion during WAIT_DONE has no effect.
- `exec_done` edge → IDLE next cycle. Back-to-back issues are therefore spaced by ≥3 cycles (ISSUE, ≥1 WAIT_DONE, IDLE).
- All outputs are registered.

## Configuration
- `INSTR_PERF_CNT_EN` defined: `busy_cycles` increments every cycle in ISSUE or WAIT_DONE. `stall_cycles` increments every cycle in IDLE with queue non-empty and `&src_ready`=0. Both saturate at 2^32-1.
- `INSTR_PERF_CNT_EN` undefined: both ports are tied to 0 and no counter logic is synthesised.

## Test plan
- Single instruction, A/B ready, engine returns `exec_done` 5 cycles after issue → one `ack` pulse, `issue_instr`==instr, `completed`=1, `done`=1.
- Push 5 instructions with DEPTH=4 and `src_ready`=0 → 4 acks, `fifo_level`=4, 5th held without ack. Then `src_ready`=2'b11 → 5th accepted after the first pop; issue order 0..4.
- `src_ready`=2'b01 for 10 cycles with 1 queued, then 2'b11 → no issue during the 10 cycles; `stall_cycles`=10 with `INSTR_PERF_CNT_EN`, 0 without.
- `exec_done` pulsed in IDLE → `err`=1 and stays 1; `completed` unchanged.
- Reset asserted in WAIT_DONE with 2 queued → all outputs at reset values; `fifo_level`=0 after release; stale entries never issued.
- CNT_W=2, 5 instructions completed → `completed` wraps 3→0→1.
